// File: rtl/wildcard_sel_pkg.sv
// Shared types and helpers for the wildcard select matcher: table entry layout and match rule.
package wildcard_sel_pkg;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned N_ENT = 8;
  localparam int unsigned IDX_W = $clog2(N_ENT);
  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic             en;
    logic [SEL_W-1:0] pat;
    logic [SEL_W-1:0] mask;
  } ent_t;

  // Mask bit set = don't-care; a fully masked enabled entry matches any select word.
  function automatic logic f_match(input logic [SEL_W-1:0] sel, input ent_t ent);
    return ent.en && (((sel ^ ent.pat) & ~ent.mask) == '0);
  endfunction

endpackage

// File: rtl/wsm_prio_enc.sv
// Lowest-index priority encoder: multi-hot request vector to hit flag plus index (0 when no hit).
module wsm_prio_enc #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec_i,
  output logic             hit_c_o,
  output logic [IDX_W-1:0] idx_c_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    hit_c_o = 1'b0;
    idx_c_o = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        hit_c_o = 1'b1;
        idx_c_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wildcard_sel_matcher.sv
// Programmable wildcard pattern table with registered lowest-index match result and saturating miss counter.
// Optional X/Z select checker (simulation only) enabled by defining SEL_XCHK_EN.
module wildcard_sel_matcher #(
  parameter int unsigned SEL_W = wildcard_sel_pkg::SEL_W,
  parameter int unsigned N_ENT = wildcard_sel_pkg::N_ENT,
  parameter int unsigned CNT_W = wildcard_sel_pkg::CNT_W,
  parameter int unsigned IDX_W = $clog2(N_ENT)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_idx_i,
  input  logic [SEL_W-1:0] cfg_pat_i,
  input  logic [SEL_W-1:0] cfg_mask_i,
  input  logic             cfg_en_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [SEL_W-1:0] in_sel_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_hit_o,
  output logic [IDX_W-1:0] out_idx_o,
  output logic             out_xflag_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] x_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  wildcard_sel_pkg::ent_t table_q [N_ENT];

  logic [N_ENT-1:0] match_c;
  logic             hit_c;
  logic [IDX_W-1:0] idx_c;
  logic             sel_x_c;
  logic             accept_c;

  logic             out_valid_q, out_valid_d;
  logic             out_hit_q,   out_hit_d;
  logic [IDX_W-1:0] out_idx_q,   out_idx_d;
  logic             out_xflag_q, out_xflag_d;
  logic [CNT_W-1:0] miss_cnt_q,  miss_cnt_d;
  logic [CNT_W-1:0] x_cnt_q,     x_cnt_d;

  // Table write; lookups in the same cycle see the old contents.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(N_ENT); i++) table_q[i] <= '0;
    end else if (cfg_we_i) begin
      table_q[cfg_idx_i] <= '{en: cfg_en_i, pat: cfg_pat_i, mask: cfg_mask_i};
    end
  end

  always_comb begin
    match_c = '0;
    for (int i = 0; i < int'(N_ENT); i++) match_c[i] = wildcard_sel_pkg::f_match(in_sel_i, table_q[i]);
  end

  wsm_prio_enc #(
    .N     (N_ENT),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .vec_i   (match_c),
    .hit_c_o (hit_c),
    .idx_c_o (idx_c)
  );

`ifdef SEL_XCHK_EN
  assign sel_x_c = $isunknown(in_sel_i);
`else
  assign sel_x_c = 1'b0;
`endif

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept_c   = in_valid_i && in_ready_o;

  always_comb begin
    out_valid_d = out_valid_q;
    out_hit_d   = out_hit_q;
    out_idx_d   = out_idx_q;
    out_xflag_d = out_xflag_q;
    miss_cnt_d  = miss_cnt_q;
    x_cnt_d     = x_cnt_q;
    if (accept_c) begin
      out_valid_d = 1'b1;
      out_hit_d   = hit_c && !sel_x_c;
      out_idx_d   = sel_x_c ? '0 : idx_c;
      out_xflag_d = sel_x_c;
      if (sel_x_c) begin
        if (x_cnt_q != CNT_MAX) x_cnt_d = x_cnt_q + CNT_W'(1);
      end else if (!hit_c) begin
        if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_idx_q   <= '0;
      out_xflag_q <= 1'b0;
      miss_cnt_q  <= '0;
      x_cnt_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_hit_q   <= out_hit_d;
      out_idx_q   <= out_idx_d;
      out_xflag_q <= out_xflag_d;
      miss_cnt_q  <= miss_cnt_d;
      x_cnt_q     <= x_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_hit_o   = out_hit_q;
  assign out_idx_o   = out_idx_q;
  assign out_xflag_o = out_xflag_q;
  assign miss_cnt_o  = miss_cnt_q;
  assign x_cnt_o     = x_cnt_q;

endmodule

// File: tb/tb_wildcard_sel_matcher.sv
// Directed self-checking bench for wildcard_sel_matcher; X/Z checks run when SEL_XCHK_EN is defined.
module tb_wildcard_sel_matcher;

  localparam int unsigned SEL_W = 4;
  localparam int unsigned N_ENT = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             cfg_we_i;
  logic [IDX_W-1:0] cfg_idx_i;
  logic [SEL_W-1:0] cfg_pat_i;
  logic [SEL_W-1:0] cfg_mask_i;
  logic             cfg_en_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [SEL_W-1:0] in_sel_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             out_hit_o;
  logic [IDX_W-1:0] out_idx_o;
  logic             out_xflag_o;
  logic [CNT_W-1:0] miss_cnt_o;
  logic [CNT_W-1:0] x_cnt_o;

  int passed = 0;
  int total  = 0;

  wildcard_sel_matcher #(
    .SEL_W (SEL_W),
    .N_ENT (N_ENT),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_idx_i   (cfg_idx_i),
    .cfg_pat_i   (cfg_pat_i),
    .cfg_mask_i  (cfg_mask_i),
    .cfg_en_i    (cfg_en_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_sel_i    (in_sel_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_hit_o   (out_hit_o),
    .out_idx_o   (out_idx_o),
    .out_xflag_o (out_xflag_o),
    .miss_cnt_o  (miss_cnt_o),
    .x_cnt_o     (x_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_ent(input int idx, input logic en, input logic [3:0] pat, input logic [3:0] mask);
    cfg_we_i   = 1'b1;
    cfg_idx_i  = IDX_W'(idx);
    cfg_en_i   = en;
    cfg_pat_i  = pat;
    cfg_mask_i = mask;
    cycle();
    cfg_we_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    cycle();
    cycle();
    reset_i = 1'b0;
    cycle();
    total++; if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); else passed++;
    total++; if (out_valid_o !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); else passed++;
    total++; if (out_hit_o !== 1'b0) $display("FAIL reset_out_hit got=%b exp=0", out_hit_o); else passed++;
    total++; if (out_idx_o !== 3'd0) $display("FAIL reset_out_idx got=%0d exp=0", out_idx_o); else passed++;
    total++; if (out_xflag_o !== 1'b0) $display("FAIL reset_xflag got=%b exp=0", out_xflag_o); else passed++;
    total++; if (miss_cnt_o !== 8'd0) $display("FAIL reset_miss_cnt got=%0d exp=0", miss_cnt_o); else passed++;
    total++; if (x_cnt_o !== 8'd0) $display("FAIL reset_x_cnt got=%0d exp=0", x_cnt_o); else passed++;
  endtask

  task automatic test_empty_lookup();
    in_valid_i = 1'b1;
    in_sel_i   = 4'h5;
    cycle();
    in_valid_i = 1'b0;
    total++; if (out_valid_o !== 1'b1) $display("FAIL empty_valid got=%b exp=1", out_valid_o); else passed++;
    total++; if (out_hit_o !== 1'b0) $display("FAIL empty_hit got=%b exp=0", out_hit_o); else passed++;
    total++; if (out_idx_o !== 3'd0) $display("FAIL empty_idx got=%0d exp=0", out_idx_o); else passed++;
    total++; if (miss_cnt_o !== 8'd1) $display("FAIL empty_miss_cnt got=%0d exp=1", miss_cnt_o); else passed++;
    cycle();
    total++; if (out_valid_o !== 1'b0) $display("FAIL empty_pop_valid got=%b exp=0", out_valid_o); else passed++;
  endtask

  task automatic test_wildcard_match();
    write_ent(2, 1'b1, 4'b1010, 4'b0001);
    write_ent(5, 1'b1, 4'b0000, 4'b1111);
    in_valid_i = 1'b1;
    in_sel_i   = 4'hB;
    cycle();
    total++; if ({out_valid_o, out_hit_o, out_idx_o} !== {1'b1, 1'b1, 3'd2}) $display("FAIL match_B got v/h/i=%b%b/%0d exp=11/2", out_valid_o, out_hit_o, out_idx_o); else passed++;
    in_sel_i = 4'hA;
    cycle();
    total++; if ({out_valid_o, out_hit_o, out_idx_o} !== {1'b1, 1'b1, 3'd2}) $display("FAIL match_A got v/h/i=%b%b/%0d exp=11/2", out_valid_o, out_hit_o, out_idx_o); else passed++;
    in_sel_i = 4'h3;
    cycle();
    in_valid_i = 1'b0;
    total++; if ({out_valid_o, out_hit_o, out_idx_o} !== {1'b1, 1'b1, 3'd5}) $display("FAIL match_default got v/h/i=%b%b/%0d exp=11/5", out_valid_o, out_hit_o, out_idx_o); else passed++;
    total++; if (miss_cnt_o !== 8'd1) $display("FAIL match_miss_cnt got=%0d exp=1", miss_cnt_o); else passed++;
    cycle();
  endtask

  task automatic test_collision();
    cfg_we_i   = 1'b1;
    cfg_idx_i  = 3'd0;
    cfg_en_i   = 1'b1;
    cfg_pat_i  = 4'h3;
    cfg_mask_i = 4'h0;
    in_valid_i = 1'b1;
    in_sel_i   = 4'h3;
    cycle();
    cfg_we_i = 1'b0;
    total++; if ({out_hit_o, out_idx_o} !== {1'b1, 3'd5}) $display("FAIL collide_prewrite got h/i=%b/%0d exp=1/5", out_hit_o, out_idx_o); else passed++;
    cycle();
    in_valid_i = 1'b0;
    total++; if ({out_hit_o, out_idx_o} !== {1'b1, 3'd0}) $display("FAIL collide_postwrite got h/i=%b/%0d exp=1/0", out_hit_o, out_idx_o); else passed++;
    cycle();
  endtask

  task automatic test_back_to_back();
    in_valid_i = 1'b1;
    in_sel_i   = 4'hB;
    cycle();
    out_ready_i = 1'b0;
    in_sel_i    = 4'h3;
    #1;
    total++; if (in_ready_o !== 1'b0) $display("FAIL bp_in_ready got=%b exp=0", in_ready_o); else passed++;
    for (int k = 0; k < 3; k++) begin
      cycle();
      total++; if ({out_valid_o, out_hit_o, out_idx_o, in_ready_o} !== {1'b1, 1'b1, 3'd2, 1'b0})
        $display("FAIL bp_hold%0d got v/h/i/r=%b%b/%0d/%b exp=11/2/0", k, out_valid_o, out_hit_o, out_idx_o, in_ready_o); else passed++;
    end
    out_ready_i = 1'b1;
    #1;
    total++; if (in_ready_o !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready_o); else passed++;
    cycle();
    total++; if ({out_valid_o, out_hit_o, out_idx_o} !== {1'b1, 1'b1, 3'd0}) $display("FAIL bp_stream0 got v/h/i=%b%b/%0d exp=11/0", out_valid_o, out_hit_o, out_idx_o); else passed++;
    in_sel_i = 4'hA;
    cycle();
    total++; if ({out_valid_o, out_hit_o, out_idx_o} !== {1'b1, 1'b1, 3'd2}) $display("FAIL bp_stream1 got v/h/i=%b%b/%0d exp=11/2", out_valid_o, out_hit_o, out_idx_o); else passed++;
    in_sel_i = 4'h5;
    cycle();
    in_valid_i = 1'b0;
    total++; if ({out_valid_o, out_hit_o, out_idx_o} !== {1'b1, 1'b1, 3'd5}) $display("FAIL bp_stream2 got v/h/i=%b%b/%0d exp=11/5", out_valid_o, out_hit_o, out_idx_o); else passed++;
    total++; if (miss_cnt_o !== 8'd1) $display("FAIL bp_miss_cnt got=%0d exp=1", miss_cnt_o); else passed++;
    cycle();
  endtask

`ifdef SEL_XCHK_EN
  task automatic test_xcheck();
    logic [3:0] xsel;
    xsel       = 4'bx0x0;
    in_valid_i = 1'b1;
    in_sel_i   = xsel;
    cycle();
    total++; if ({out_xflag_o, out_hit_o, out_idx_o} !== {1'b1, 1'b0, 3'd0}) $display("FAIL x_first got x/h/i=%b%b/%0d exp=10/0", out_xflag_o, out_hit_o, out_idx_o); else passed++;
    total++; if (x_cnt_o !== 8'd1) $display("FAIL x_cnt1 got=%0d exp=1", x_cnt_o); else passed++;
    in_sel_i = 'z;
    cycle();
    in_valid_i = 1'b0;
    in_sel_i   = 4'h0;
    total++; if ({out_xflag_o, out_hit_o, out_idx_o} !== {1'b1, 1'b0, 3'd0}) $display("FAIL x_second got x/h/i=%b%b/%0d exp=10/0", out_xflag_o, out_hit_o, out_idx_o); else passed++;
    total++; if (x_cnt_o !== 8'd2) $display("FAIL x_cnt2 got=%0d exp=2", x_cnt_o); else passed++;
    total++; if (miss_cnt_o !== 8'd1) $display("FAIL x_miss_cnt got=%0d exp=1", miss_cnt_o); else passed++;
    cycle();
  endtask
`endif

  task automatic test_saturate();
    write_ent(5, 1'b0, 4'h0, 4'hF);
    in_valid_i = 1'b1;
    in_sel_i   = 4'h5;
    for (int k = 0; k < 300; k++) begin
      cycle();
      if (k == 99) begin
        total++; if (miss_cnt_o !== 8'd101) $display("FAIL sat_mid got=%0d exp=101", miss_cnt_o); else passed++;
      end
    end
    in_valid_i = 1'b0;
    total++; if (miss_cnt_o !== 8'd255) $display("FAIL sat_end got=%0d exp=255", miss_cnt_o); else passed++;
    total++; if ({out_valid_o, out_hit_o} !== {1'b1, 1'b0}) $display("FAIL sat_out got v/h=%b%b exp=10", out_valid_o, out_hit_o); else passed++;
    cycle();
  endtask

  task automatic test_reset_mid();
    in_valid_i = 1'b1;
    in_sel_i   = 4'h3;
    cycle();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    total++; if ({out_valid_o, out_hit_o, out_idx_o} !== {1'b1, 1'b1, 3'd0}) $display("FAIL rmid_pre got v/h/i=%b%b/%0d exp=11/0", out_valid_o, out_hit_o, out_idx_o); else passed++;
    reset_i = 1'b1;
    cycle();
    reset_i     = 1'b0;
    out_ready_i = 1'b1;
    total++; if ({out_valid_o, miss_cnt_o} !== {1'b0, 8'd0}) $display("FAIL rmid_cleared got v/miss=%b/%0d exp=0/0", out_valid_o, miss_cnt_o); else passed++;
    in_valid_i = 1'b1;
    cycle();
    in_valid_i = 1'b0;
    total++; if ({out_valid_o, out_hit_o, out_idx_o} !== {1'b1, 1'b0, 3'd0}) $display("FAIL rmid_table got v/h/i=%b%b/%0d exp=10/0", out_valid_o, out_hit_o, out_idx_o); else passed++;
    total++; if (miss_cnt_o !== 8'd1) $display("FAIL rmid_miss got=%0d exp=1", miss_cnt_o); else passed++;
    cycle();
  endtask

  initial begin
    reset_i     = 1'b1;
    cfg_we_i    = 1'b0;
    cfg_idx_i   = '0;
    cfg_pat_i   = '0;
    cfg_mask_i  = '0;
    cfg_en_i    = 1'b0;
    in_valid_i  = 1'b0;
    in_sel_i    = '0;
    out_ready_i = 1'b1;
    test_reset();
    test_empty_lookup();
    test_wildcard_match();
    test_collision();
    test_back_to_back();
`ifdef SEL_XCHK_EN
    test_xcheck();
`endif
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
